// File: rtl/flag_sequencer_if.sv
// Instruction and flag-side bus between the decode/execute stages and the
// flag sequencer. The master drives requests and the slave is the sequencer.
interface flag_sequencer_if;
    logic       id_valid;
    logic [3:0] id_cond;
    logic       id_s;
    logic       id_ready;
    logic       issue_valid;
    logic       issue_exec;
    logic       flag_wb_valid;
    logic [3:0] flag_wb_data;
    logic       sr_wr_en;
    logic [3:0] sr_wr_data;
    logic       flush;
    logic [3:0] sr;
    logic [1:0] pending;
    logic [7:0] stall_cnt;
    logic       proto_err;

    modport master (
        output id_valid, id_cond, id_s, flag_wb_valid, flag_wb_data,
               sr_wr_en, sr_wr_data, flush,
        input  id_ready, issue_valid, issue_exec, sr, pending, stall_cnt,
               proto_err
    );

    modport slave (
        input  id_valid, id_cond, id_s, flag_wb_valid, flag_wb_data,
               sr_wr_en, sr_wr_data, flush,
        output id_ready, issue_valid, issue_exec, sr, pending, stall_cnt,
               proto_err
    );
endinterface

// File: rtl/flag_sequencer.sv
// Condition-code sequencer: holds conditional instructions until in-flight
// flag-setters have returned their flags, then issues them to EXE.
module flag_sequencer (
    input logic           clk,
    input logic           rst_n,
    flag_sequencer_if.slave bus
);
    typedef enum logic {ST_RUN, ST_WAIT} state_t;

    state_t     state;
    state_t     next_state;
    logic [3:0] sr;
    logic [1:0] pending;
    logic [7:0] stall_cnt;
    logic       issue_valid;
    logic       issue_exec;
    logic       proto_err;

    logic [3:0] sr_eff;
    logic       cond_pass;
    logic       dec;
    logic [1:0] pend_after;
    logic       blocked;
    logic       accept;
    logic       stall_inc;

    // Flags returning this cycle are forwarded so a waiting instruction can
    // issue in the same cycle its producer completes.
    always_comb begin
        sr_eff = (bus.flag_wb_valid && pending != 2'd0) ? bus.flag_wb_data : sr;
        cond_pass = 1'b0;
        case (bus.id_cond)
            4'b0000: cond_pass = sr_eff[2];
            4'b0001: cond_pass = !sr_eff[2];
            4'b0010: cond_pass = sr_eff[1];
            4'b0011: cond_pass = !sr_eff[1];
            4'b0100: cond_pass = sr_eff[3];
            4'b0101: cond_pass = !sr_eff[3];
            4'b0110: cond_pass = sr_eff[0];
            4'b0111: cond_pass = !sr_eff[0];
            4'b1000: cond_pass = sr_eff[1] && !sr_eff[2];
            4'b1001: cond_pass = !sr_eff[1] || sr_eff[2];
            4'b1010: cond_pass = sr_eff[3] == sr_eff[0];
            4'b1011: cond_pass = sr_eff[3] != sr_eff[0];
            4'b1100: cond_pass = !sr_eff[2] && (sr_eff[3] == sr_eff[0]);
            4'b1101: cond_pass = sr_eff[2] || (sr_eff[3] != sr_eff[0]);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    always_comb begin
        dec        = bus.flag_wb_valid && pending != 2'd0 && !bus.flush;
        pend_after = pending - {1'b0, dec};
        blocked    = ((bus.id_cond[3:1] != 3'b111) && pend_after != 2'd0)
                   || (bus.id_s && pend_after == 2'd3);
        accept     = bus.id_valid && !bus.flush && !blocked;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_RUN:  if (bus.id_valid && blocked && !bus.flush) next_state = ST_WAIT;
            ST_WAIT: if (accept || !bus.id_valid || bus.flush) next_state = ST_RUN;
            default: next_state = ST_RUN;
        endcase
    end

    always_comb begin
        stall_inc = (state == ST_WAIT) || (next_state == ST_WAIT);
    end

    // Flag writeback outranks a direct write; a failed-condition flag-setter
    // never commits, so it does not count as outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr          <= 4'b0000;
            pending     <= 2'd0;
            issue_valid <= 1'b0;
            issue_exec  <= 1'b0;
            stall_cnt   <= 8'd0;
            proto_err   <= 1'b0;
        end else begin
            issue_valid <= accept;
            issue_exec  <= accept && cond_pass;
            if (bus.flush) begin
                pending <= 2'd0;
            end else begin
                pending <= pend_after + {1'b0, accept && bus.id_s && cond_pass};
            end
            if (dec) begin
                sr <= bus.flag_wb_data;
            end else if (bus.sr_wr_en && pending == 2'd0) begin
                sr <= bus.sr_wr_data;
            end
            if ((bus.flag_wb_valid && pending == 2'd0 && !bus.flush)
                || (bus.sr_wr_en && pending != 2'd0)) begin
                proto_err <= 1'b1;
            end
            if (stall_inc && stall_cnt != 8'hFF) begin
                stall_cnt <= stall_cnt + 8'd1;
            end
        end
    end

    assign bus.id_ready    = !bus.flush && !blocked;
    assign bus.issue_valid = issue_valid;
    assign bus.issue_exec  = issue_exec;
    assign bus.sr          = sr;
    assign bus.pending     = pending;
    assign bus.stall_cnt   = stall_cnt;
    assign bus.proto_err   = proto_err;
endmodule

// File: tb/tb_flag_sequencer.sv
// Directed bench for flag_sequencer; expected issue results are queued when an
// instruction is driven and compared once the registered issue appears.
module tb_flag_sequencer;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    typedef struct {
        string tag;
        logic  v;
        logic  e;
    } exp_t;

    exp_t sbq[$];

    flag_sequencer_if bus ();

    flag_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of inputs and queues the issue result expected after the edge.
    task automatic applyStimulus(input logic v, input logic [3:0] cond, input logic s,
                                 input logic wbv, input logic [3:0] wbd,
                                 input logic srw, input logic [3:0] srd, input logic fl,
                                 input logic expv, input logic expe, input string tag);
        exp_t item;
        bus.id_valid      = v;
        bus.id_cond       = cond;
        bus.id_s          = s;
        bus.flag_wb_valid = wbv;
        bus.flag_wb_data  = wbd;
        bus.sr_wr_en      = srw;
        bus.sr_wr_data    = srd;
        bus.flush         = fl;
        item.tag = tag;
        item.v   = expv;
        item.e   = expe;
        sbq.push_back(item);
        #1;
    endtask

    task automatic stepCycle();
        exp_t item;
        @(posedge clk);
        #1;
        item = sbq.pop_front();
        checkOutput({item.tag, ".valid"}, {7'd0, bus.issue_valid}, {7'd0, item.v});
        checkOutput({item.tag, ".exec"}, {7'd0, bus.issue_exec}, {7'd0, item.e});
    endtask

    task automatic idle(input string tag);
        applyStimulus(0, 4'hE, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, tag);
        stepCycle();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        bus.id_valid = 0; bus.id_cond = 4'hE; bus.id_s = 0;
        bus.flag_wb_valid = 0; bus.flag_wb_data = 0;
        bus.sr_wr_en = 0; bus.sr_wr_data = 0; bus.flush = 0;
        #12;
        checkOutput("rst.sr", {4'd0, bus.sr}, 8'h00);
        checkOutput("rst.pending", {6'd0, bus.pending}, 8'h00);
        checkOutput("rst.issue_valid", {7'd0, bus.issue_valid}, 8'h00);
        checkOutput("rst.proto_err", {7'd0, bus.proto_err}, 8'h00);
        checkOutput("rst.stall_cnt", bus.stall_cnt, 8'h00);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Direct write Z, then EQ passes and NE fails
        applyStimulus(0, 4'hE, 0, 0, 4'h0, 1, 4'b0100, 0, 0, 0, "srwr");
        stepCycle();
        checkOutput("srwr.sr", {4'd0, bus.sr}, 8'h04);
        applyStimulus(1, 4'h0, 0, 0, 4'h0, 0, 4'h0, 0, 1, 1, "eq");
        checkOutput("eq.ready", {7'd0, bus.id_ready}, 8'h01);
        stepCycle();
        applyStimulus(1, 4'h1, 0, 0, 4'h0, 0, 4'h0, 0, 1, 0, "ne");
        stepCycle();

        // Flag-setter then GT waits until the writeback forwards 0000
        applyStimulus(1, 4'hE, 1, 0, 4'h0, 0, 4'h0, 0, 1, 1, "al_s");
        stepCycle();
        checkOutput("al_s.pending", {6'd0, bus.pending}, 8'h01);
        applyStimulus(1, 4'hC, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, "gt_blk");
        checkOutput("gt_blk.ready", {7'd0, bus.id_ready}, 8'h00);
        stepCycle();
        checkOutput("gt_blk.stall_cnt", bus.stall_cnt, 8'h01);
        applyStimulus(1, 4'hC, 0, 1, 4'b0000, 0, 4'h0, 0, 1, 1, "gt_fwd");
        checkOutput("gt_fwd.ready", {7'd0, bus.id_ready}, 8'h01);
        stepCycle();
        checkOutput("gt_fwd.sr", {4'd0, bus.sr}, 8'h00);
        checkOutput("gt_fwd.pending", {6'd0, bus.pending}, 8'h00);

        // Three flag-setters fill pending; a fourth needs a same-cycle writeback
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 4'hE, 1, 0, 4'h0, 0, 4'h0, 0, 1, 1, "fill");
            stepCycle();
        end
        checkOutput("fill.pending", {6'd0, bus.pending}, 8'h03);
        applyStimulus(1, 4'hE, 1, 0, 4'h0, 0, 4'h0, 0, 0, 0, "fourth_blk");
        checkOutput("fourth_blk.ready", {7'd0, bus.id_ready}, 8'h00);
        stepCycle();
        applyStimulus(1, 4'hE, 1, 1, 4'b1001, 0, 4'h0, 0, 1, 1, "fourth_wb");
        checkOutput("fourth_wb.ready", {7'd0, bus.id_ready}, 8'h01);
        stepCycle();
        checkOutput("fourth_wb.pending", {6'd0, bus.pending}, 8'h03);
        checkOutput("fourth_wb.sr", {4'd0, bus.sr}, 8'h09);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 4'hE, 0, 1, 4'b0000, 0, 4'h0, 0, 0, 0, "drain");
            stepCycle();
        end
        checkOutput("drain.pending", {6'd0, bus.pending}, 8'h00);

        // HI under two flag values, NV, and a failed flag-setter
        applyStimulus(0, 4'hE, 0, 0, 4'h0, 1, 4'b0010, 0, 0, 0, "sr0010");
        stepCycle();
        applyStimulus(1, 4'h8, 0, 0, 4'h0, 0, 4'h0, 0, 1, 1, "hi_pass");
        stepCycle();
        applyStimulus(0, 4'hE, 0, 0, 4'h0, 1, 4'b0110, 0, 0, 0, "sr0110");
        stepCycle();
        applyStimulus(1, 4'h8, 0, 0, 4'h0, 0, 4'h0, 0, 1, 0, "hi_fail");
        stepCycle();
        applyStimulus(1, 4'hF, 0, 0, 4'h0, 0, 4'h0, 0, 1, 0, "nv");
        stepCycle();
        applyStimulus(1, 4'h8, 1, 0, 4'h0, 0, 4'h0, 0, 1, 0, "hi_s_fail");
        stepCycle();
        checkOutput("hi_s_fail.pending", {6'd0, bus.pending}, 8'h00);

        // Protocol errors: stray writeback, then direct write while busy
        applyStimulus(0, 4'hE, 0, 1, 4'b1111, 0, 4'h0, 0, 0, 0, "stray_wb");
        stepCycle();
        checkOutput("stray_wb.proto_err", {7'd0, bus.proto_err}, 8'h01);
        checkOutput("stray_wb.sr", {4'd0, bus.sr}, 8'h06);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 4'hE, 1, 0, 4'h0, 0, 4'h0, 0, 1, 1, "two_s");
            stepCycle();
        end
        applyStimulus(0, 4'hE, 0, 0, 4'h0, 1, 4'b1111, 0, 0, 0, "busy_wr");
        stepCycle();
        checkOutput("busy_wr.proto_err", {7'd0, bus.proto_err}, 8'h01);
        checkOutput("busy_wr.sr", {4'd0, bus.sr}, 8'h06);
        checkOutput("busy_wr.pending", {6'd0, bus.pending}, 8'h02);

        // Flush discards pending and ignores the writeback; GE then issues
        applyStimulus(1, 4'hA, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, "ge_wait");
        stepCycle();
        applyStimulus(1, 4'hA, 0, 1, 4'b1000, 0, 4'h0, 1, 0, 0, "flush");
        checkOutput("flush.ready", {7'd0, bus.id_ready}, 8'h00);
        stepCycle();
        checkOutput("flush.pending", {6'd0, bus.pending}, 8'h00);
        checkOutput("flush.sr", {4'd0, bus.sr}, 8'h06);
        applyStimulus(1, 4'hA, 0, 0, 4'h0, 0, 4'h0, 0, 1, 1, "ge_go");
        stepCycle();

        // Reset in the middle of a stall; EQ then evaluates against 0000
        applyStimulus(1, 4'hE, 1, 0, 4'h0, 0, 4'h0, 0, 1, 1, "pre_rst");
        stepCycle();
        applyStimulus(1, 4'h0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, "eq_stall");
        stepCycle();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst.sr", {4'd0, bus.sr}, 8'h00);
        checkOutput("midrst.pending", {6'd0, bus.pending}, 8'h00);
        checkOutput("midrst.stall_cnt", bus.stall_cnt, 8'h00);
        checkOutput("midrst.proto_err", {7'd0, bus.proto_err}, 8'h00);
        #2;
        rst_n = 1'b1;
        applyStimulus(1, 4'h0, 0, 0, 4'h0, 0, 4'h0, 0, 1, 0, "eq_after_rst");
        stepCycle();
        idle("tail");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/flag_sequencer.md
FLAG_SEQUENCER -- requirements
Module: flag_sequencer

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with ports named as follows.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active low.
REQ-003 The block SHALL have these instruction-side ports.
- id_valid  input  1  decode stage offers an instruction.
- id_cond  input  4  condition field of the offered instruction.
- id_s  input  1  offered instruction updates flags when it executes.
- id_ready  output  1  instruction is accepted this cycle when id_valid&&id_ready.
- issue_valid  output  1  registered; an accepted instruction is presented to EXE.
- issue_exec  output  1  registered; condition passed, so EXE commits the instruction.
REQ-004 The block SHALL have these flag-side ports.
- flag_wb_valid  input  1  EXE returns flags for the oldest pending flag-setter.
- flag_wb_data  input  4  returned flags, [3]=N [2]=Z [1]=C [0]=V.
- sr_wr_en  input  1  direct status write (MSR-style).
- sr_wr_data  input  4  direct status write value.
- flush  input  1  pipeline flush.
- sr  output  4  architectural status register, same bit order as flag_wb_data.
- pending  output  2  count of outstanding flag-setters.
- stall_cnt  output  8  saturating count of stall cycles.
- proto_err  output  1  sticky protocol-error flag.

Function
REQ-005 The block SHALL evaluate id_cond against sr_eff, where sr_eff = flag_wb_data if flag_wb_valid && pending!=0, else sr.
REQ-006 The block SHALL decode id_cond as follows.
- 0000 EQ: Z.
- 0001 NE: !Z.
- 0010 CS: C.
- 0011 CC: !C.
- 0100 MI: N.
- 0101 PL: !N.
- 0110 VS: V.
- 0111 VC: !V.
- 1000 HI: C&&!Z.
- 1001 LS: !C||Z.
- 1010 GE: N==V.
- 1011 LT: N!=V.
- 1100 GT: !Z&&N==V.
- 1101 LE: Z||N!=V.
- 1110 AL: 1.
- 1111 NV: 0.
REQ-007 The block SHALL compute dec = flag_wb_valid && pending!=0 && !flush, and pend_after = pending - dec.
REQ-008 The block SHALL block an instruction with id_cond not in {AL, NV} while pend_after != 0.
REQ-009 The block SHALL block an instruction with id_s=1 while pend_after == 3.
REQ-010 id_ready SHALL equal !flush && !blocked; AL and NV instructions SHALL never be blocked by flags, except as required by REQ-009.
REQ-011 On acceptance, the block SHALL register issue_valid=1 and issue_exec=condition result on the next edge (latency 1); otherwise issue_valid=0 and issue_exec=0.
REQ-012 pending SHALL increment on acceptance with id_s=1 and issue_exec=1.
- Increment and decrement in the same cycle SHALL leave pending unchanged.
- A failed-condition flag-setter SHALL NOT increment pending.
REQ-013 sr SHALL be updated as follows.
- On dec, sr SHALL load flag_wb_data.
- Else, on sr_wr_en && pending==0, sr SHALL load sr_wr_data.
- flag_wb has priority over sr_wr_en.
REQ-014 The block SHALL set proto_err (sticky until reset) on any of the following.
- flag_wb_valid while pending==0; the write SHALL be ignored.
- sr_wr_en while pending!=0; the write SHALL be ignored.
REQ-015 On flush, the block SHALL set pending to 0, issue_valid to 0 and issue_exec to 0.
- No instruction SHALL be accepted in a flush cycle.
- flag_wb_valid in a flush cycle SHALL be ignored without error.
- sr SHALL be unchanged unless sr_wr_en is set.
REQ-016 The block SHALL implement a two-state FSM.
- RUN -> WAIT when id_valid && blocked && !flush.
- WAIT -> RUN on acceptance, on !id_valid, or on flush.
REQ-017 stall_cnt SHALL increment by 1 in each cycle spent in WAIT or entering WAIT, and SHALL saturate at 255.

Reset
REQ-018 While rst_n=0, the block SHALL asynchronously set the following.
- sr=0000.
- pending=0.
- issue_valid=0.
- issue_exec=0.
- stall_cnt=0.
- proto_err=0.
- FSM state=RUN.
REQ-019 Reset asserted mid-stall SHALL discard the held instruction's state, and the first accept after release SHALL use sr=0000.

Verification
REQ-020 The bench SHALL cover the following directed scenarios.
- Reset, sr_wr 0100, then EQ instruction -> issue_valid=1, issue_exec=1 next cycle; NE instruction -> issue_exec=0.
- Flag-setter AL id_s=1 accepted (pending=1); next cycle GT offered -> id_ready=0, stall_cnt=1; flag_wb 0000 -> same-cycle accept, issue_exec=1, sr=0000, pending=0.
- Three AL id_s=1 accepted -> pending=3; fourth id_s=1 blocked; with flag_wb in the same cycle it is accepted, pending stays 3.
- HI with sr=0010 -> exec=1; sr=0110 -> exec=0; NV with any sr -> issue_valid=1, exec=0; failed id_s instruction leaves pending unchanged.
- flag_wb_valid with pending=0 -> proto_err=1 and sr unchanged; sr_wr_en with pending=2 -> proto_err stays 1 and sr unchanged.
- pending=2 and GE waiting, flush with flag_wb -> pending=0, issue_valid=0, sr unchanged; next cycle GE accepted.
